// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: owner and FSM state encodings,
// the timeout counter width and a helper that maps an owner to its ack lines.
package mem_arbiter_pkg;

    // Current grant holder as seen on the owner output.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2,
        OWN_TB   = 2'd3
    } owner_t;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The BUSY cycle counter must hold TIMEOUT values up to 255.
    localparam int CNT_W = 8;

    // Ack vector {tb, dm, if} for a given owner; OWN_NONE acks nobody.
    function automatic logic [2:0] ack_onehot(input owner_t own);
        logic [2:0] acks;
        acks = 3'b000;
        case (own)
            OWN_TB:  acks = 3'b100;
            OWN_DM:  acks = 3'b010;
            OWN_IF:  acks = 3'b001;
            default: acks = 3'b000;
        endcase
        return acks;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the single memory
// port. The master modport is the environment side (requesters and memory),
// the slave modport is the arbiter side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);

    // Instruction-fetch read port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;

    // CPU data port
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;

    // Loader port
    logic              tb_req;
    logic              tb_we;
    logic [ADDR_W-1:0] tb_addr;
    logic [DATA_W-1:0] tb_wdata;
    logic              tb_ack;

    // Shared read data and status
    logic [DATA_W-1:0] rdata;
    logic [1:0]        owner;
    logic              err;

    // Memory command and response
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output tb_req, tb_we, tb_addr, tb_wdata,
        output mem_rdata, mem_ready,
        input  if_ack, dm_ack, tb_ack,
        input  rdata, owner, err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  tb_req, tb_we, tb_addr, tb_wdata,
        input  mem_rdata, mem_ready,
        output if_ack, dm_ack, tb_ack,
        output rdata, owner, err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_arb_select.sv
// Combinational winner selection for the memory arbiter.
// The loader port always wins. A DM/IF tie goes to DM unless ARB_ROUND_ROBIN_EN
// is defined, in which case it goes to whichever of the two was not served last.
module arb_select
    import mem_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   dm_req,
    input  logic   tb_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic   last_if,
`endif
    output owner_t winner
);

    // Fixed priority for TB, configurable tie-break between DM and IF.
    always_comb begin
        winner = OWN_NONE;
        if (tb_req) begin
            winner = OWN_TB;
        end else if (dm_req && if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = last_if ? OWN_DM : OWN_IF;
`else
            winner = OWN_DM;
`endif
        end else if (dm_req) begin
            winner = OWN_DM;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-port memory arbiter (IF, DM, TB) in front of a single memory port.
// IDLE picks a winner and latches its command, BUSY drives the memory until
// mem_ready or a timeout, DONE pulses the winner's ack for one cycle.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin DM/IF tie-break).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    // Counter value seen in the last BUSY cycle allowed before timing out:
    // the counter is 0 in the first BUSY cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    owner_t             owner_q;
    owner_t             winner;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               if_ack_q;
    logic               dm_ack_q;
    logic               tb_ack_q;
    logic               err_q;
    logic [CNT_W-1:0]   busy_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    logic               last_if_q;
`endif

    arb_select u_arb_select (
        .if_req  (bus.if_req),
        .dm_req  (bus.dm_req),
        .tb_req  (bus.tb_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_if (last_if_q),
`endif
        .winner  (winner)
    );

    // Arbiter FSM with registered command, ack, error and timeout state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner_q     <= OWN_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            tb_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            busy_cnt    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_if_q   <= 1'b1;
`endif
        end else begin
            // Acks and err are single-cycle pulses; only the BUSY exit sets them.
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            tb_ack_q <= 1'b0;
            err_q    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (winner != OWN_NONE) begin
                        state     <= ST_BUSY;
                        owner_q   <= winner;
                        mem_req_q <= 1'b1;
                        busy_cnt  <= '0;
                        case (winner)
                            OWN_TB: begin
                                mem_we_q    <= bus.tb_we;
                                mem_addr_q  <= bus.tb_addr;
                                mem_wdata_q <= bus.tb_wdata;
                            end
                            OWN_DM: begin
                                mem_we_q    <= bus.dm_we;
                                mem_addr_q  <= bus.dm_addr;
                                mem_wdata_q <= bus.dm_wdata;
                            end
                            default: begin
                                // Instruction fetch is read-only.
                                mem_we_q    <= 1'b0;
                                mem_addr_q  <= bus.if_addr;
                                mem_wdata_q <= '0;
                            end
                        endcase
`ifdef ARB_ROUND_ROBIN_EN
                        // TB grants leave the DM/IF history untouched.
                        if (winner == OWN_IF) begin
                            last_if_q <= 1'b1;
                        end else if (winner == OWN_DM) begin
                            last_if_q <= 1'b0;
                        end
`endif
                    end
                end

                ST_BUSY: begin
                    if (bus.mem_ready) begin
                        // A response on the timeout cycle still counts as success.
                        state     <= ST_DONE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        rdata_q   <= bus.mem_rdata;
                        {tb_ack_q, dm_ack_q, if_ack_q} <= ack_onehot(owner_q);
                    end else if (busy_cnt == CNT_LAST) begin
                        state     <= ST_DONE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        {tb_ack_q, dm_ack_q, if_ack_q} <= ack_onehot(owner_q);
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    state    <= ST_IDLE;
                    owner_q  <= OWN_NONE;
                    busy_cnt <= '0;
                end

                default: begin
                    state     <= ST_IDLE;
                    owner_q   <= OWN_NONE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    busy_cnt  <= '0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.owner     = owner_q;
    assign bus.err       = err_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.tb_ack    = tb_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected completion of
// each transaction, a monitor pops and compares on every ack, a memory model
// answers mem_req after a programmable number of BUSY cycles.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  owner;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int tests = 0;
    int fails = 0;

    // Memory model controls
    int          delay    = 1;
    bit          never    = 1'b0;
    bit          spurious = 1'b0;
    int          cyc      = 0;
    logic        last_we  = 1'b0;
    logic [15:0] last_addr  = 16'h0;
    logic [15:0] last_wdata = 16'h0;

    function automatic logic [15:0] mem_lookup(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hBEEF;
            16'h0020: return 16'h1234;
            16'h0030: return 16'h5678;
            16'h0040: return 16'h9ABC;
            default:  return 16'hDEAD;
        endcase
    endfunction

    function automatic logic [2:0] want_acks(input logic [1:0] o);
        case (o)
            2'd3:    return 3'b100;
            2'd2:    return 3'b010;
            2'd1:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] o, input logic we, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] rd, input logic e);
        exp_t x;
        x.owner = o; x.we = we; x.addr = a; x.wdata = wd; x.rdata = rd; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [15:0] a, input logic [15:0] wd);
        case (p)
            1: begin bus.if_req = req; bus.if_addr = a; end
            2: begin bus.dm_req = req; bus.dm_we = we; bus.dm_addr = a; bus.dm_wdata = wd; end
            default: begin bus.tb_req = req; bus.tb_we = we; bus.tb_addr = a; bus.tb_wdata = wd; end
        endcase
    endtask

    function automatic logic ack_of(input int p);
        case (p)
            1:       return bus.if_ack;
            2:       return bus.dm_ack;
            default: return bus.tb_ack;
        endcase
    endfunction

    // Raise a request, hold it until the port's ack, then drop it.
    task automatic serve(input int p, input logic we, input logic [15:0] a, input logic [15:0] wd);
        bit got;
        got = 1'b0;
        drive(p, 1'b1, we, a, wd);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack_of(p)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL serve_wait port %0d: no ack within 200 cycles, ack required", p);
        end
        drive(p, 1'b0, we, a, wd);
    endtask

    // Memory model: mem_ready in the delay-th BUSY cycle, stray ready when idle on request.
    always @(negedge clk) begin
        if (bus.mem_req) begin
            cyc        = cyc + 1;
            last_we    = bus.mem_we;
            last_addr  = bus.mem_addr;
            last_wdata = bus.mem_wdata;
            bus.mem_ready = !never && (cyc == delay);
            bus.mem_rdata = mem_lookup(bus.mem_addr);
        end else begin
            cyc = 0;
            bus.mem_ready = spurious;
            bus.mem_rdata = spurious ? 16'hFFFF : 16'h0000;
        end
    end

    // Monitor: every ack must match the oldest expected completion.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.if_ack || bus.dm_ack || bus.tb_ack) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: acks(tb,dm,if)=%b, required none", {bus.tb_ack, bus.dm_ack, bus.if_ack});
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_vector", {29'd0, bus.tb_ack, bus.dm_ack, bus.if_ack}, {29'd0, want_acks(mon_e.owner)});
                    chk("ack_owner", {30'd0, bus.owner}, {30'd0, mon_e.owner});
                    chk("ack_rdata", {16'd0, bus.rdata}, {16'd0, mon_e.rdata});
                    chk("ack_err", {31'd0, bus.err}, {31'd0, mon_e.err});
                    chk("cmd_we", {31'd0, last_we}, {31'd0, mon_e.we});
                    chk("cmd_addr", {16'd0, last_addr}, {16'd0, mon_e.addr});
                    chk("cmd_wdata", {16'd0, last_wdata}, {16'd0, mon_e.wdata});
                end
            end else if (bus.err) begin
                tests++;
                fails++;
                $display("FAIL err_without_ack: err=1, required 0");
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, finish required earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int  busy;
        bit  got;

        bus.if_req = 1'b0; bus.if_addr = 16'h0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 16'h0; bus.dm_wdata = 16'h0;
        bus.tb_req = 1'b0; bus.tb_we = 1'b0; bus.tb_addr = 16'h0; bus.tb_wdata = 16'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 16'h0;
        reset = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_owner", {30'd0, bus.owner}, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_acks_err", {28'd0, bus.tb_ack, bus.dm_ack, bus.if_ack, bus.err}, 32'd0);
        chk("rst_rdata", {16'd0, bus.rdata}, 32'd0);
        chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
        reset = 1'b0;

        // No request, stray mem_ready: stay idle
        spurious = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("idle_owner", {30'd0, bus.owner}, 32'd0);
        spurious = 1'b0;
        @(negedge clk);

        // Single IF read, memory ready in cycle 2 with 0xBEEF
        delay = 2;
        push(2'd1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        drive(1, 1'b1, 1'b0, 16'h0010, 16'h0);
        @(negedge clk);
        chk("if_c1_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("if_c1_owner", {30'd0, bus.owner}, 32'd1);
        chk("if_c1_mem_addr", {16'd0, bus.mem_addr}, 32'h0010);
        @(negedge clk);
        chk("if_c2_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("if_c2_owner", {30'd0, bus.owner}, 32'd1);
        @(negedge clk);
        chk("if_c3_ack", {31'd0, bus.if_ack}, 32'd1);
        chk("if_c3_rdata", {16'd0, bus.rdata}, 32'hBEEF);
        chk("if_c3_owner", {30'd0, bus.owner}, 32'd1);
        chk("if_c3_mem_req", {31'd0, bus.mem_req}, 32'd0);
        drive(1, 1'b0, 1'b0, 16'h0010, 16'h0);
        @(negedge clk);
        chk("if_c4_owner", {30'd0, bus.owner}, 32'd0);
        chk("if_c4_ack", {31'd0, bus.if_ack}, 32'd0);

        // All three at once: TB, then DM, then IF
        delay = 1;
        push(2'd3, 1'b1, 16'h0040, 16'h1111, 16'h9ABC, 1'b0);
        push(2'd2, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0);
        push(2'd1, 1'b0, 16'h0030, 16'h0000, 16'h5678, 1'b0);
        fork
            serve(3, 1'b1, 16'h0040, 16'h1111);
            serve(2, 1'b0, 16'h0020, 16'h0000);
            serve(1, 1'b0, 16'h0030, 16'h0000);
        join
        @(negedge clk);

        // DM and IF both held for four transactions
`ifdef ARB_ROUND_ROBIN_EN
        push(2'd2, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0);
        push(2'd1, 1'b0, 16'h0030, 16'h0000, 16'h5678, 1'b0);
        push(2'd2, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0);
        push(2'd1, 1'b0, 16'h0030, 16'h0000, 16'h5678, 1'b0);
`else
        push(2'd2, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0);
        push(2'd2, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0);
        push(2'd1, 1'b0, 16'h0030, 16'h0000, 16'h5678, 1'b0);
        push(2'd1, 1'b0, 16'h0030, 16'h0000, 16'h5678, 1'b0);
`endif
        fork
            begin
                serve(2, 1'b0, 16'h0020, 16'h0000);
                @(negedge clk);
                serve(2, 1'b0, 16'h0020, 16'h0000);
            end
            begin
                serve(1, 1'b0, 16'h0030, 16'h0000);
                @(negedge clk);
                serve(1, 1'b0, 16'h0030, 16'h0000);
            end
        join
        @(negedge clk);

        // Memory never answers: ack and err after the 15th BUSY cycle
        never = 1'b1;
        push(2'd2, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b1);
        drive(2, 1'b1, 1'b0, 16'h0020, 16'h0);
        busy = 0;
        got  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.dm_ack) begin
                got = 1'b1;
                break;
            end
            if (bus.mem_req) busy++;
        end
        chk("to_ack_seen", {31'd0, got}, 32'd1);
        chk("to_busy_cycles", busy, 32'd15);
        drive(2, 1'b0, 1'b0, 16'h0020, 16'h0);
        @(negedge clk);
        chk("to_idle_owner", {30'd0, bus.owner}, 32'd0);
        chk("to_idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
        never = 1'b0;

        // Ready on the timeout cycle completes without err
        delay = 15;
        push(2'd2, 1'b0, 16'h0040, 16'h0000, 16'h9ABC, 1'b0);
        serve(2, 1'b0, 16'h0040, 16'h0000);
        @(negedge clk);

        // Reset in the second BUSY cycle of a DM write aborts it
        delay = 5;
        drive(2, 1'b1, 1'b1, 16'h0020, 16'hCAFE);
        @(negedge clk);
        chk("abort_c1_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("abort_c1_mem_we", {31'd0, bus.mem_we}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("abort_owner", {30'd0, bus.owner}, 32'd0);
        chk("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
        drive(2, 1'b0, 1'b1, 16'h0020, 16'hCAFE);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        delay = 1;
        push(2'd2, 1'b1, 16'h0020, 16'hCAFE, 16'h1234, 1'b0);
        serve(2, 1'b1, 16'h0020, 16'hCAFE);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
